// File: rtl/uart_beep_pkg.sv
// rtl/uart_beep_pkg.sv - shared types, constants and helpers for the UART beep controller
package uart_beep_pkg;

  // Receiver frame-tracking states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam logic [7:0] CMD_ON_DEFAULT  = 8'h31;
  localparam logic [7:0] CMD_OFF_DEFAULT = 8'h30;

  // Width of the optional auto-off counter
  localparam int TIMEOUT_W = 28;

  // Last value of the per-bit cycle counter
  function automatic int baud_cnt_max(input int clk_freq, input int baud);
    return clk_freq / baud - 1;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART byte receiver with input synchroniser and framing check
module uart_rx_byte
  import uart_beep_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int CNT_MAX = baud_cnt_max(CLK_FREQ, BAUD);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CNT_MAX / 2);

  logic             rx_meta;
  logic             rx_sync;
  logic             rx_prev;
  logic             rx_fall;
  logic             bit_mid;
  rx_state_t        state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;

  // Two-flop synchroniser plus one delay stage for falling-edge detection; idles high
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // A held-low line produces no edge, so a break cannot retrigger reception
  assign rx_fall = rx_prev & ~rx_sync;
  assign bit_mid = (baud_cnt == CNT_MID);

  // Frame FSM: the bit timer starts at the start-bit edge and runs freely through the frame
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (state == IDLE || baud_cnt == CNT_LAST) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (rx_fall) begin
            state <= START;
          end
        end
        START: begin
          // A line that is high again at mid start bit was only a glitch
          if (bit_mid) begin
            state <= rx_sync ? IDLE : DATA;
          end
        end
        DATA: begin
          if (bit_mid) begin
            shift[bit_cnt] <= rx_sync;
            bit_cnt        <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
            end
          end
        end
        STOP: begin
          if (bit_mid) begin
            if (rx_sync) begin
              rx_data  <= shift;
              rx_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_beep_ctrl.sv
// rtl/uart_beep_ctrl.sv - UART command decoder driving beep_flag; UART_BEEP_TIMEOUT_EN adds auto-off
module uart_beep_ctrl
  import uart_beep_pkg::*;
#(
  parameter int         CLK_FREQ       = 50_000_000,
  parameter int         BAUD           = 9600,
  parameter logic [7:0] CMD_ON         = CMD_ON_DEFAULT,
  parameter logic [7:0] CMD_OFF        = CMD_OFF_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 250_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       uart_rx,
  output logic       beep_flag,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err
);

  logic cmd_on;
  logic cmd_off;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 2 ** TIMEOUT_W) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES does not fit the auto-off counter");
  end

  uart_rx_byte #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_rx (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .uart_rx   (uart_rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  // Only correctly framed bytes are decoded; framing errors never reach the flag
  assign cmd_on  = rx_valid && (rx_data == CMD_ON);
  assign cmd_off = rx_valid && (rx_data == CMD_OFF);

`ifdef UART_BEEP_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_W-1:0] timeout_cnt;

  // Beep flag with auto-off; a fresh ON restarts the window and beats a coincident timeout
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      beep_flag   <= 1'b0;
      timeout_cnt <= '0;
    end else if (cmd_on) begin
      beep_flag   <= 1'b1;
      timeout_cnt <= '0;
    end else if (cmd_off) begin
      beep_flag   <= 1'b0;
      timeout_cnt <= '0;
    end else if (beep_flag) begin
      if (timeout_cnt == TIMEOUT_LAST) begin
        beep_flag   <= 1'b0;
        timeout_cnt <= '0;
      end else begin
        timeout_cnt <= timeout_cnt + 1'b1;
      end
    end else begin
      timeout_cnt <= '0;
    end
  end
`else
  // Beep flag holds until an OFF command or reset
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      beep_flag <= 1'b0;
    end else if (cmd_on) begin
      beep_flag <= 1'b1;
    end else if (cmd_off) begin
      beep_flag <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_beep_ctrl.sv
// tb/tb_uart_beep_ctrl.sv - scoreboard bench for uart_beep_ctrl; UART_BEEP_TIMEOUT_EN adds the auto-off step
module tb_uart_beep_ctrl;
  import uart_beep_pkg::*;

  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD     = 1_000_000;
  localparam int BIT      = CLK_FREQ / BAUD;
  localparam int TIMEOUT  = 1000;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       uart_rx = 1'b1;
  logic       beep_flag;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;

  int n_cmp   = 0;
  int n_bad   = 0;
  int n_valid = 0;
  int n_ferr  = 0;
  int n_unexp = 0;
  int cyc     = 0;
  int rise_cyc = -1;
  int fall_cyc = -1;
  int model_on_cyc = 0;
  int v0, f0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  logic       model_beep = 1'b0;
  logic       beep_d     = 1'b0;
  bit         chk_next   = 1'b0;

  uart_beep_ctrl #(
    .CLK_FREQ       (CLK_FREQ),
    .BAUD           (BAUD),
    .CMD_ON         (8'h31),
    .CMD_OFF        (8'h30),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .uart_rx   (uart_rx),
    .beep_flag (beep_flag),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  always #10 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    tick(BIT);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(BIT);
    end
    uart_rx = stop;
    tick(BIT);
    uart_rx = 1'b1;
    tick(BIT);
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    tick(3);
    sys_rst = 1'b0;
    model_beep = 1'b0;
    chk_next   = 1'b0;
    exp_q.delete();
  endtask

  // Scoreboard and beep model, sampled on the falling edge
  always @(negedge sys_clk) begin
`ifdef UART_BEEP_TIMEOUT_EN
    if (model_beep && (cyc >= model_on_cyc + TIMEOUT)) model_beep = 1'b0;
`endif
    if (chk_next) begin
      check("beep_after_rx", beep_flag, model_beep);
      chk_next = 1'b0;
    end
    if (rx_valid || frame_err) check("valid_ferr_excl", rx_valid & frame_err, 0);
    if (frame_err) n_ferr++;
    if (rx_valid) begin
      n_valid++;
      check("beep_before_rx", beep_flag, model_beep);
      if (exp_q.size() == 0) begin
        n_unexp++;
      end else begin
        exp_b = exp_q.pop_front();
        check("rx_data", rx_data, exp_b);
        if (exp_b == 8'h31) begin
          model_beep   = 1'b1;
          model_on_cyc = cyc + 1;
        end else if (exp_b == 8'h30) begin
          model_beep = 1'b0;
        end
        chk_next = 1'b1;
      end
    end
    if (beep_flag && !beep_d) rise_cyc = cyc;
    if (!beep_flag && beep_d) fall_cyc = cyc;
    beep_d = beep_flag;
  end

  initial begin
    repeat (100000) @(posedge sys_clk);
    $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    check("rst_beep", beep_flag, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_state", dut.u_rx.state, IDLE);
    tick(2 * BIT);

    exp_q.push_back(8'h31);
    send_frame(8'h31, 1'b1);
    check("on_count", n_valid, 1);
    check("on_beep", beep_flag, 1'b1);
    check("on_rx_data", rx_data, 8'h31);

    exp_q.push_back(8'h30);
    send_frame(8'h30, 1'b1);
    check("off_count", n_valid, 2);
    check("off_beep", beep_flag, 1'b0);

    exp_q.push_back(8'h31);
    send_frame(8'h31, 1'b1);
    exp_q.push_back(8'h41);
    send_frame(8'h41, 1'b1);
    check("other_count", n_valid, 4);
    check("other_rx_data", rx_data, 8'h41);
    check("other_beep", beep_flag, model_beep);

    v0 = n_valid;
    f0 = n_ferr;
    uart_rx = 1'b0;
    tick(10);
    uart_rx = 1'b1;
    tick(3 * BIT);
    check("glitch_valid", n_valid, v0);
    check("glitch_ferr", n_ferr, f0);
    check("glitch_state", dut.u_rx.state, IDLE);

    exp_q.push_back(8'h30);
    send_frame(8'h30, 1'b1);
    v0 = n_valid;
    f0 = n_ferr;
    send_frame(8'h31, 1'b0);
    tick(BIT);
    check("ferr_count", n_ferr, f0 + 1);
    check("ferr_valid", n_valid, v0);
    check("ferr_rx_data", rx_data, 8'h30);
    check("ferr_beep", beep_flag, 1'b0);
    check("ferr_state", dut.u_rx.state, IDLE);

    exp_q.push_back(8'h31);
    send_frame(8'h31, 1'b1);
    check("pre_rst_beep", beep_flag, model_beep);
    v0 = n_valid;
    f0 = n_ferr;
    uart_rx = 1'b0;
    tick(BIT);
    for (int i = 0; i < 4; i++) begin
      uart_rx = exp_b[i];
      tick(BIT);
    end
    uart_rx = 1'b1;
    tick(BIT / 2);
    do_reset();
    tick(12 * BIT);
    check("midrst_valid", n_valid, v0);
    check("midrst_ferr", n_ferr, f0);
    check("midrst_beep", beep_flag, 1'b0);
    check("midrst_rx_data", rx_data, 8'h00);
    exp_q.push_back(8'h30);
    send_frame(8'h30, 1'b1);
    check("postrst_count", n_valid, v0 + 1);
    check("postrst_rx_data", rx_data, 8'h30);
    check("postrst_beep", beep_flag, 1'b0);

`ifdef UART_BEEP_TIMEOUT_EN
    rise_cyc = -1;
    fall_cyc = -1;
    exp_q.push_back(8'h31);
    send_frame(8'h31, 1'b1);
    for (int i = 0; i < 3 * TIMEOUT && beep_flag; i++) tick(1);
    tick(2);
    check("timeout_fell", beep_flag, 1'b0);
    check("timeout_len", fall_cyc - rise_cyc, TIMEOUT);
`endif

    check("unexpected_rx", n_unexp, 0);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
